tracker_edit_sequencer: RTL

TRACKER_EDIT_SEQUENCER -- requirements
Module: tracker_edit_sequencer

---
 rtl/tracker_pkg.sv | 58 +++++
 rtl/tracker_cell_edit.sv | 77 +++++++
 rtl/tracker_edit_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/tracker_pkg.sv
// tracker_pkg
//   Shared types and constants for the tracker cell editor.
//   action_e / sel_e encode the edit request fields; ASCII constants and the
//   note-order table define the cell code space; HI_* / LO_* give the VRAM
//   bit positions of the two 7-bit code characters {hi,lo}.
package tracker_pkg;

   typedef enum logic [1:0] {
      ACT_NONE = 2'b00,
      ACT_INC  = 2'b01,
      ACT_DEC  = 2'b10,
      ACT_DEL  = 2'b11
   } action_e;

   typedef enum logic [1:0] {
      SEL_NOTE = 2'b00,
      SEL_OCT  = 2'b01,
      SEL_INST = 2'b10,
      SEL_VOL  = 2'b11
   } sel_e;

   localparam logic [7:0] ASC_0    = 8'h30;
   localparam logic [7:0] ASC_HASH = 8'h23;
   localparam logic [7:0] ASC_A    = 8'h41;
   localparam logic [7:0] ASC_B    = 8'h42;
   localparam logic [7:0] ASC_C    = 8'h43;
   localparam logic [7:0] ASC_D    = 8'h44;
   localparam logic [7:0] ASC_E    = 8'h45;
   localparam logic [7:0] ASC_F    = 8'h46;
   localparam logic [7:0] ASC_G    = 8'h47;

   localparam int HI_MSB = 30;
   localparam int HI_LSB = 24;
   localparam int LO_MSB = 14;
   localparam int LO_LSB = 8;

   localparam int NOTE_CNT = 12;

   // Chromatic order C..B; a natural has lo=00h, a sharp has lo='#'.
   function automatic logic [15:0] note_code(input logic [3:0] idx);
      case (idx)
         4'd0:    note_code = {ASC_C, 8'h00};
         4'd1:    note_code = {ASC_C, ASC_HASH};
         4'd2:    note_code = {ASC_D, 8'h00};
         4'd3:    note_code = {ASC_D, ASC_HASH};
         4'd4:    note_code = {ASC_E, 8'h00};
         4'd5:    note_code = {ASC_F, 8'h00};
         4'd6:    note_code = {ASC_F, ASC_HASH};
         4'd7:    note_code = {ASC_G, 8'h00};
         4'd8:    note_code = {ASC_G, ASC_HASH};
         4'd9:    note_code = {ASC_A, 8'h00};
         4'd10:   note_code = {ASC_A, ASC_HASH};
         4'd11:   note_code = {ASC_B, 8'h00};
         default: note_code = 16'h0000;
      endcase
   endfunction

endpackage

// File: rtl/tracker_cell_edit.sv
// tracker_cell_edit
//   Pure combinational edit of one cell code pair {hi,lo}.
//   action   in  2   none / increment / decrement / delete
//   sel      in  2   note / octave / instrument / volume
//   pair_in  in  16  current {hi,lo} code
//   pair_out out 16  edited code; unrecognised codes come back unchanged
module tracker_cell_edit
   import tracker_pkg::*;
(
   input  logic [1:0]  action,
   input  logic [1:0]  sel,
   input  logic [15:0] pair_in,
   output logic [15:0] pair_out
);

   action_e    act;
   sel_e       fld;
   logic [7:0] hi, lo;
   logic       up;

   assign act = action_e'(action);
   assign fld = sel_e'(sel);
   assign hi  = pair_in[15:8];
   assign lo  = pair_in[7:0];
   assign up  = (act == ACT_INC);

   // single digit fields: octave '0'..'7', instrument '0'..'3'
   logic [7:0] dig_max, dig_nxt;
   logic       dig_ok;
   assign dig_max = (fld == SEL_OCT) ? ASC_0 + 8'd7 : ASC_0 + 8'd3;
   assign dig_ok  = (hi == 8'h00) && (lo >= ASC_0) && (lo <= dig_max);
   assign dig_nxt = up ? ((lo == dig_max) ? ASC_0 : lo + 8'd1)
                       : ((lo == ASC_0) ? dig_max : lo - 8'd1);

   // volume "00".."63": work in binary, then split back into two digits
   logic [7:0] vol_val, vol_nxt;
   logic       vol_ok;
   assign vol_val = (hi - ASC_0) * 8'd10 + (lo - ASC_0);
   assign vol_ok  = (hi >= ASC_0) && (hi <= ASC_0 + 8'd6) &&
                    (lo >= ASC_0) && (lo <= ASC_0 + 8'd9) && (vol_val <= 8'd63);
   assign vol_nxt = up ? ((vol_val == 8'd63) ? 8'd0 : vol_val + 8'd1)
                       : ((vol_val == 8'd0) ? 8'd63 : vol_val - 8'd1);

   // note: locate the code in the chromatic table
   logic [3:0] note_idx, note_nxt;
   logic       note_hit;
   always_comb begin
      note_hit = 1'b0;
      note_idx = 4'd0;
      for (int i = 0; i < NOTE_CNT; i++) begin
         if (pair_in == note_code(4'(i))) begin
            note_hit = 1'b1;
            note_idx = 4'(i);
         end
      end
   end
   assign note_nxt = up ? ((note_idx == 4'd11) ? 4'd0 : note_idx + 4'd1)
                        : ((note_idx == 4'd0) ? 4'd11 : note_idx - 4'd1);

   always_comb begin
      pair_out = pair_in;
      case (act)
         ACT_DEL: pair_out = 16'h0000;
         ACT_INC, ACT_DEC: begin
            case (fld)
               SEL_NOTE:          if (note_hit) pair_out = note_code(note_nxt);
               SEL_OCT, SEL_INST: if (dig_ok)   pair_out = {8'h00, dig_nxt};
               SEL_VOL:           if (vol_ok)   pair_out = {ASC_0 + vol_nxt / 8'd10,
                                                            ASC_0 + vol_nxt % 8'd10};
               default:           pair_out = pair_in;
            endcase
         end
         default: pair_out = pair_in;
      endcase
   end

endmodule

// File: rtl/tracker_edit_sequencer.sv
// tracker_edit_sequencer
//   Read-modify-write sequencer for tracker cell edits on a shared VRAM port.
//   Build option: TRACKER_EDIT_FIFO_EN selects a 4-entry request FIFO
//   instead of the single holding register.
//   axi_aclk, axi_aresetn        clock, async active-low reset
//   req_valid/req_ready          edit request handshake
//   req_addr, req_action, req_sel  target word, action, field
//   bus_req/bus_gnt              AXI-side VRAM port arbitration
//   vram_addr/we/wdata, vram_rdata  sequencer VRAM port
//   done                         one-cycle pulse per completed request
//   busy                         high while not IDLE
module tracker_edit_sequencer
   import tracker_pkg::*;
#(
   parameter int ADDR_W     = 11,
   parameter int READ_LAT   = 2,
   parameter int STARVE_MAX = 8
)(
   input  logic              axi_aclk,
   input  logic              axi_aresetn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [1:0]        req_action,
   input  logic [1:0]        req_sel,
   input  logic              bus_req,
   output logic              bus_gnt,
   output logic [ADDR_W-1:0] vram_addr,
   output logic              vram_we,
   output logic [31:0]       vram_wdata,
   input  logic [31:0]       vram_rdata,
   output logic              done,
   output logic              busy
);

   localparam int SW = $clog2(STARVE_MAX + 1);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [1:0]        action;
      logic [1:0]        sel;
   } req_t;

   typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WRITE} state_e;

   state_e        state;
   logic          live;          // low until the first clock after reset
   logic          force_slot;
   logic [SW-1:0] starve_cnt;
   logic [1:0]    wait_cnt;
   logic [1:0]    cur_action, cur_sel;

   req_t head;
   logic head_vld, head_rmw, push, pop, go_rd, go_nop;

   assign push     = req_valid && req_ready;
   assign head_rmw = head_vld && (head.action != ACT_NONE);
   assign bus_gnt  = live && bus_req && (state == IDLE) && !force_slot;
   assign go_rd    = (state == IDLE) && head_rmw && !bus_gnt;
   // no-op requests complete straight from IDLE without touching the port
   assign go_nop   = (state == IDLE) && head_vld && (head.action == ACT_NONE);
   assign pop      = go_rd || go_nop;

`ifdef TRACKER_EDIT_FIFO_EN
   req_t       fifo_mem [4];
   logic [1:0] wr_ptr, rd_ptr;
   logic [2:0] fifo_cnt;

   always_ff @(posedge axi_aclk)
      if (push) fifo_mem[wr_ptr] <= {req_addr, req_action, req_sel};

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 2'd1;
         if (pop)  rd_ptr <= rd_ptr + 2'd1;
         fifo_cnt <= fifo_cnt + 3'(push) - 3'(pop);
      end
   end

   assign head      = fifo_mem[rd_ptr];
   assign head_vld  = (fifo_cnt != 3'd0);
   assign req_ready = live && (fifo_cnt != 3'd4);
`else
   req_t hold;
   logic held;

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         hold <= '0;
         held <= 1'b0;
      end else if (push) begin
         hold <= {req_addr, req_action, req_sel};
         held <= 1'b1;
      end else if (pop) begin
         held <= 1'b0;
      end
   end

   assign head      = hold;
   assign head_vld  = held;
   assign req_ready = live && (state == IDLE) && !held;
`endif

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         state      <= IDLE;
         live       <= 1'b0;
         done       <= 1'b0;
         busy       <= 1'b0;
         vram_we    <= 1'b0;
         vram_addr  <= '0;
         wait_cnt   <= '0;
         cur_action <= '0;
         cur_sel    <= '0;
         force_slot <= 1'b0;
         starve_cnt <= '0;
      end else begin
         live    <= 1'b1;
         done    <= 1'b0;
         vram_we <= 1'b0;
         case (state)
            IDLE: begin
               if (go_rd) begin
                  state      <= RD_REQ;
                  busy       <= 1'b1;
                  vram_addr  <= head.addr;
                  cur_action <= head.action;
                  cur_sel    <= head.sel;
               end else if (go_nop) begin
                  done <= 1'b1;
               end
            end
            RD_REQ: begin
               // WRITE lands READ_LAT cycles after RD_REQ, when rdata is valid
               if (READ_LAT == 1) begin
                  state   <= WRITE;
                  vram_we <= 1'b1;
                  done    <= 1'b1;
               end else begin
                  state    <= RD_WAIT;
                  wait_cnt <= 2'(READ_LAT - 2);
               end
            end
            RD_WAIT: begin
               if (wait_cnt == 2'd0) begin
                  state   <= WRITE;
                  vram_we <= 1'b1;
                  done    <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt - 2'd1;
               end
            end
            WRITE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase

         // Starvation: after STARVE_MAX straight grant cycles with real work
         // waiting, withhold the grant for one slot.
         if (go_rd)
            force_slot <= 1'b0;
         else if (bus_gnt && head_rmw && (starve_cnt >= SW'(STARVE_MAX - 1)))
            force_slot <= 1'b1;

         if (bus_gnt) begin
            if (starve_cnt != SW'(STARVE_MAX)) starve_cnt <= starve_cnt + SW'(1);
         end else begin
            starve_cnt <= '0;
         end
      end
   end

   // Edit path: rdata is valid during WRITE, so the write data is combinational.
   logic [15:0] pair_in, pair_out;
   logic        pair_unused;
   logic [31:0] edited;

   assign pair_in     = {1'b0, vram_rdata[HI_MSB:HI_LSB], 1'b0, vram_rdata[LO_MSB:LO_LSB]};
   assign pair_unused = pair_out[15] | pair_out[7];

   tracker_cell_edit u_edit (
      .action   (cur_action),
      .sel      (cur_sel),
      .pair_in  (pair_in),
      .pair_out (pair_out)
   );

   always_comb begin
      edited                = vram_rdata;
      edited[HI_MSB:HI_LSB] = pair_out[14:8];
      edited[LO_MSB:LO_LSB] = pair_out[6:0];
   end

   assign vram_wdata = (state == WRITE) ? edited : 32'h0;

endmodule
